// File: rtl/rng_share_arbiter.sv
// rng_share_arbiter: round-robin burst arbiter sharing one random source among NUM_REQ consumers
//   clk            rising-edge clock
//   reset          asynchronous active-high reset
//   enable         permits new grants (running bursts always finish)
//   rng_data       free-running random sample
//   req            level request per requester
//   grant          registered one-hot grant
//   out_valid      out_data/out_id hold a fresh sample
//   out_data       registered sample
//   out_id         owner of out_data
//   samples_served wrap-around count of delivered samples
module rng_share_arbiter #(
   parameter  int NUM_REQ   = 4,
   parameter  int DATA_W    = 8,
   parameter  int BURST_LEN = 4,
   localparam int IW        = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [DATA_W-1:0]  rng_data,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] grant,
   output logic               out_valid,
   output logic [DATA_W-1:0]  out_data,
   output logic [IW-1:0]      out_id,
   output logic [15:0]        samples_served
);
   typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
   localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
   localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
   state_t             state_q, state_d;
   logic [NUM_REQ-1:0] grant_q, grant_d;
   logic [IW-1:0]      cur_q, cur_d, rr_ptr_q, rr_ptr_d, out_id_q, out_id_d, win;
   logic [BW-1:0]      beat_cnt_q, beat_cnt_d;
   logic               out_valid_q, out_valid_d, found;
   logic [DATA_W-1:0]  out_data_q, out_data_d;
   logic [15:0]        samples_served_q, samples_served_d;
   // first requester at or after rr_ptr, searching upward with wrap-around
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
            found = 1'b1;
            win   = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
         end
      end
   end
   always_comb begin
      state_d          = state_q;
      grant_d          = grant_q;
      cur_d            = cur_q;
      beat_cnt_d       = beat_cnt_q;
      rr_ptr_d         = rr_ptr_q;
      out_valid_d      = 1'b0;
      out_data_d       = out_data_q;
      out_id_d         = out_id_q;
      samples_served_d = samples_served_q;
      case (state_q)
         IDLE: begin
            grant_d = '0;
            if (enable && found) begin
               state_d    = BURST;
               grant_d    = NUM_REQ'(1) << win;
               cur_d      = win;
               beat_cnt_d = '0;
               rr_ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + IW'(1);
            end
         end
         BURST: begin
            if (req[cur_q]) begin
               out_valid_d      = 1'b1;
               out_data_d       = rng_data;
               out_id_d         = cur_q;
               samples_served_d = samples_served_q + 16'd1;
               beat_cnt_d       = beat_cnt_q + BW'(1);
               if (beat_cnt_q == LAST) begin
                  state_d = DRAIN;
                  grant_d = '0;
               end
            end else begin
               // owner dropped its request: abort, never restart silently
               state_d = DRAIN;
               grant_d = '0;
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         grant_q          <= '0;
         cur_q            <= '0;
         beat_cnt_q       <= '0;
         rr_ptr_q         <= '0;
         out_valid_q      <= 1'b0;
         out_data_q       <= '0;
         out_id_q         <= '0;
         samples_served_q <= '0;
      end else begin
         state_q          <= state_d;
         grant_q          <= grant_d;
         cur_q            <= cur_d;
         beat_cnt_q       <= beat_cnt_d;
         rr_ptr_q         <= rr_ptr_d;
         out_valid_q      <= out_valid_d;
         out_data_q       <= out_data_d;
         out_id_q         <= out_id_d;
         samples_served_q <= samples_served_d;
      end
   end
   assign grant          = grant_q;
   assign out_valid      = out_valid_q;
   assign out_data       = out_data_q;
   assign out_id         = out_id_q;
   assign samples_served = samples_served_q;
endmodule

// File: tb/tb_rng_share_arbiter.sv
// tb_rng_share_arbiter: directed vector and sequence checks for rng_share_arbiter
module tb_rng_share_arbiter;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic [7:0]  rng_data = 8'h00;
   logic [3:0]  req = 4'b0000;
   logic [3:0]  grant;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_id;
   logic [15:0] samples_served;
   int tests = 0;
   int fails = 0;

   rng_share_arbiter #(.NUM_REQ(4), .DATA_W(8), .BURST_LEN(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .rng_data(rng_data), .req(req),
      .grant(grant), .out_valid(out_valid), .out_data(out_data), .out_id(out_id),
      .samples_served(samples_served)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic [3:0]  req;
      logic [7:0]  rng;
      logic [3:0]  grant;
      logic        ov;
      logic [7:0]  data;
      logic [1:0]  id;
      logic [15:0] served;
   } vec_t;
   vec_t vecs[8];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      req = 4'b0000;
      enable = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic count_beats(input string name);
      int beats = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (out_valid) beats++;
         if (grant == 4'b0000) break;
      end
      chk(name, beats, 4);
   endtask

   initial begin
      vecs[0] = '{1'b1, 4'b0100, 8'h10, 4'b0100, 1'b0, 8'h00, 2'd0, 16'd0};
      vecs[1] = '{1'b1, 4'b0100, 8'h11, 4'b0100, 1'b1, 8'h11, 2'd2, 16'd1};
      vecs[2] = '{1'b1, 4'b0100, 8'h12, 4'b0100, 1'b1, 8'h12, 2'd2, 16'd2};
      vecs[3] = '{1'b1, 4'b0100, 8'h13, 4'b0100, 1'b1, 8'h13, 2'd2, 16'd3};
      vecs[4] = '{1'b1, 4'b0100, 8'h14, 4'b0000, 1'b1, 8'h14, 2'd2, 16'd4};
      vecs[5] = '{1'b1, 4'b0100, 8'h15, 4'b0000, 1'b0, 8'h14, 2'd2, 16'd4};
      vecs[6] = '{1'b1, 4'b0100, 8'h16, 4'b0100, 1'b0, 8'h14, 2'd2, 16'd4};
      vecs[7] = '{1'b1, 4'b0100, 8'h17, 4'b0100, 1'b1, 8'h17, 2'd2, 16'd5};

      do_reset();
      chk("rst_grant", grant, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_data", out_data, 0);
      chk("rst_id", out_id, 0);
      chk("rst_served", samples_served, 0);

      for (int v = 0; v < 8; v++) begin
         enable = vecs[v].en;
         req = vecs[v].req;
         rng_data = vecs[v].rng;
         tick();
         chk($sformatf("v%0d_grant", v), grant, vecs[v].grant);
         chk($sformatf("v%0d_valid", v), out_valid, vecs[v].ov);
         chk($sformatf("v%0d_data", v), out_data, vecs[v].data);
         chk($sformatf("v%0d_id", v), out_id, vecs[v].id);
         chk($sformatf("v%0d_served", v), samples_served, vecs[v].served);
      end

      // round robin with all requesters asserting
      do_reset();
      enable = 1'b1;
      req = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         logic [3:0] exp_g;
         exp_g = 4'b0001 << (g % 4);
         for (int k = 0; k < 20 && grant == 4'b0000; k++) tick();
         chk($sformatf("rr_grant%0d", g), grant, exp_g);
         if (g < 4) count_beats($sformatf("rr_beats%0d", g));
         if (g == 3) chk("rr_served16", samples_served, 16);
      end
      tick();
      chk("rr_midburst_valid", out_valid, 1);
      // asynchronous reset mid-burst, checked before the next edge
      reset = 1'b1;
      #1;
      chk("async_rst_grant", grant, 0);
      chk("async_rst_valid", out_valid, 0);
      chk("async_rst_served", samples_served, 0);
      tick();
      reset = 1'b0;

      // abort after two beats, then another requester follows DRAIN+IDLE
      do_reset();
      enable = 1'b1;
      req = 4'b0001;
      tick();
      chk("ab_grant", grant, 4'b0001);
      tick();
      chk("ab_beat1", out_valid, 1);
      tick();
      chk("ab_beat2", out_valid, 1);
      req = 4'b0000;
      tick();
      chk("ab_valid", out_valid, 0);
      chk("ab_grant_drop", grant, 0);
      chk("ab_served", samples_served, 2);
      req = 4'b0010;
      tick();
      chk("ab_drain_grant", grant, 0);
      tick();
      chk("ab_next_grant", grant, 4'b0010);

      // enable gating
      do_reset();
      enable = 1'b0;
      req = 4'b0011;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk($sformatf("en_off_grant%0d", k), grant, 0);
      end
      chk("en_off_rr", dut.rr_ptr_q, 0);
      enable = 1'b1;
      tick();
      chk("en_on_grant", grant, 4'b0001);
      enable = 1'b0;
      count_beats("en_mid_beats");
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("en_after_grant%0d", k), grant, 0);
      end

      // counter wrap
      enable = 1'b1;
      req = 4'b0000;
      tick();
      force dut.samples_served_q = 16'hFFFF;
      tick();
      release dut.samples_served_q;
      tick();
      chk("wrap_pre", samples_served, 16'hFFFF);
      req = 4'b0100;
      rng_data = 8'hA5;
      tick();
      chk("wrap_grant", grant, 4'b0100);
      tick();
      chk("wrap_valid", out_valid, 1);
      chk("wrap_data", out_data, 8'hA5);
      chk("wrap_served", samples_served, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/rng_share_arbiter.md
Name: rng_share_arbiter

Overview:
Shares one free-running 8-bit random source among NUM_REQ requesters so that every sample goes to exactly one consumer.
- Round-robin arbitration; the winner holds a grant for a burst of up to BURST_LEN consecutive samples.
- Sits between the random generator output and its consumers (e.g. LFSR seeding, dither, test-pattern blocks).
- Keeps a wrap-around count of samples delivered.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, width of the random sample
BURST_LEN, 4, maximum samples delivered per grant (1..256)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  permits new grants; an in-progress burst always runs to completion or abort
rng_data  in  DATA_W  random sample from the generator; it changes every clock
req  in  NUM_REQ  level request, one bit per requester
grant  out  NUM_REQ  one-hot (or zero) registered grant
out_valid  out  1  out_data/out_id carry a fresh sample this cycle
out_data  out  DATA_W  registered sample
out_id  out  clog2(NUM_REQ)  index of the requester that owns out_data
samples_served  out  16  total samples delivered; wraps 0xFFFF->0x0000

Behaviour:
- Reset (async) values: state=IDLE, grant=0, out_valid=0, out_data=0, out_id=0, samples_served=0, rr_ptr=0, beat_cnt=0.
- The FSM has three states: IDLE, BURST, DRAIN. All outputs are registered.
- IDLE:
  - If enable=1 and req!=0, the winner w is the first set bit of req at or after rr_ptr, searching upward with wrap-around.
  - Next edge: state<=BURST, grant<=onehot(w), cur<=w, beat_cnt<=0, rr_ptr<=(w+1) mod NUM_REQ.
  - Otherwise stay in IDLE with grant=0.
- BURST, one beat per cycle:
  - If req[cur]=1: next edge out_valid<=1, out_data<=rng_data (sampled this cycle), out_id<=cur, samples_served+=1, beat_cnt+=1.
  - If beat_cnt==BURST_LEN-1 on that beat: next edge state<=DRAIN, grant<=0.
  - If req[cur]=0: abort. Next edge out_valid<=0, grant<=0, state<=DRAIN; no sample is delivered that cycle.
- DRAIN: exactly one cycle, grant=0, out_valid<=0, then IDLE. This guarantees one idle cycle between bursts so consumers can observe the grant drop.
- Latency: req rises in IDLE at cycle T -> grant high at T+1 -> first out_valid at T+2. Maximum beat rate is one sample per cycle.
- Samples are never duplicated. Each rng_data value is captured at most once because only one grant is active at a time.
- Requests from non-granted requesters are ignored until the next IDLE evaluation.
- Requests from the granted requester toggling mid-burst cause an abort; they are never restarted silently.
- enable going low mid-burst has no effect on the current burst. In IDLE with enable=0, no grant is issued and rr_ptr is unchanged.
- Fairness: with all requesters continuously asserting, grants rotate 0,1,2,...,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 bursts.
- Reset asserted mid-burst clears all state immediately (async). out_valid and grant drop without waiting for a clock edge.
- samples_served wraps silently; it has no saturation and no flag.
- req bits at index >= NUM_REQ do not exist. out_id width is max(1, clog2(NUM_REQ)).

Test Plan:
- Reset: assert reset mid-burst with out_valid=1 -> grant=0, out_valid=0, samples_served=0 within the same cycle, before any clock edge.
- Single request: req=4'b0100 held, rng_data=0x10,0x11,... -> grant=4'b0100 one cycle after req; four out_valid beats with out_id=2 and out_data equal to the rng_data sampled the previous cycle; grant drops, one DRAIN cycle, then the next grant is reissued to 2.
- Round robin: req=4'b1111 held for 40 cycles -> grant sequence 0001,0010,0100,1000,0001; each burst delivers 4 samples; samples_served=16 after four bursts.
- Abort: req=4'b0001, drop req[0] after the 2nd beat -> exactly 2 out_valid beats, grant=0 the next cycle, samples_served=2; then req=4'b0010 is granted after DRAIN+IDLE.
- Enable gating: enable=0 with req=4'b0011 -> no grant for 10 cycles and rr_ptr unchanged; set enable=1 -> requester 0 granted; deassert enable mid-burst -> the burst still delivers all 4 beats.
- Wrap: preload via 65535 delivered samples (or force) -> the next beat takes samples_served to 0x0000.
